alu_issue_unit: RTL and testbench

//  Front end that drives the combinational execute stage: accepts instructions over a

---
 rtl/alu_issue_if.sv | 24 ++
 rtl/alu_issue_unit.sv | 114 +++++++++++
 tb/tb_alu_issue_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Instruction handshake and execute-stage bus between the issue unit and its ALU/driver side.
// The slave modport is the issue unit; the master modport is the instruction source plus ALU.
interface alu_issue_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              exe_valid;
    logic [DATA_W-1:0] exe_operand1;
    logic [DATA_W-1:0] exe_operand2;
    logic [2:0]        exe_alu_control;
    logic [DATA_W-1:0] alu_result;

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, exe_valid, exe_operand1, exe_operand2, exe_alu_control
    );

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, exe_valid, exe_operand1, exe_operand2, exe_alu_control
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Decode/issue front end for a combinational ALU: 8x32 register file, one-deep
// execute->decode bypass, halt, debug read port and saturating retire counter.
module alu_issue_unit #(
    parameter int DATA_W   = 32,
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_if.slave          bus,
    input  logic [2:0]          dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [RETIRE_W-1:0] retired,
    output logic                halted
);
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [DATA_W-1:0]   r_rf [8];
    logic                r_vld_p1;
    logic [DATA_W-1:0]   r_op1_p1;
    logic [DATA_W-1:0]   r_op2_p1;
    logic [2:0]          r_ctrl_p1;
    logic [2:0]          r_rd_p1;
    logic [RETIRE_W-1:0] r_retired;
    logic                r_halted;

    logic [2:0]          w_op;
    logic                w_imm_sel;
    logic [2:0]          w_rd;
    logic [2:0]          w_rs1;
    logic [2:0]          w_rs2;
    logic [18:0]         w_imm19;
    logic signed [DATA_W-1:0] w_imm_ext;
    logic                w_accept;
    logic                w_issue;
    logic [DATA_W-1:0]   w_src1;
    logic [DATA_W-1:0]   w_src2;
    logic [DATA_W-1:0]   w_operand2;

    assign w_op      = bus.instr[31:29];
    assign w_imm_sel = bus.instr[28];
    assign w_rd      = bus.instr[27:25];
    assign w_rs1     = bus.instr[24:22];
    assign w_rs2     = bus.instr[21:19];
    assign w_imm19   = bus.instr[18:0];
    assign w_imm_ext = {{(DATA_W-19){w_imm19[18]}}, w_imm19};

    assign w_accept  = bus.instr_valid && !r_halted;
    assign w_issue   = w_accept && (w_op != OP_NOP) && (w_op != OP_HALT);

    // The instruction in execute has not written back yet, so its result is
    // forwarded straight from the ALU and takes priority over the register file.
    function automatic logic [DATA_W-1:0] read_src(
        input logic [2:0]        sel,
        input logic              fwd_vld,
        input logic [2:0]        fwd_rd,
        input logic [DATA_W-1:0] fwd_val,
        input logic [DATA_W-1:0] rf_val
    );
        if (sel == 3'd0)                  return '0;
        else if (fwd_vld && fwd_rd == sel) return fwd_val;
        else                               return rf_val;
    endfunction

    assign w_src1     = read_src(w_rs1, r_vld_p1, r_rd_p1, bus.alu_result, r_rf[w_rs1]);
    assign w_src2     = read_src(w_rs2, r_vld_p1, r_rd_p1, bus.alu_result, r_rf[w_rs2]);
    assign w_operand2 = w_imm_sel ? w_imm_ext : w_src2;

    // Stage p0 -> p1: decode and register operands for the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_op1_p1  <= '0;
            r_op2_p1  <= '0;
            r_ctrl_p1 <= '0;
            r_rd_p1   <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_vld_p1 <= w_issue;
            if (w_issue) begin
                r_op1_p1  <= w_src1;
                r_op2_p1  <= w_operand2;
                r_ctrl_p1 <= w_op;
                r_rd_p1   <= w_rd;
            end
            if (w_accept && w_op == OP_HALT)
                r_halted <= 1'b1;
        end
    end

    // Stage p1 -> writeback: capture the ALU result and count the retirement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++)
                r_rf[k] <= '0;
            r_retired <= '0;
        end else if (r_vld_p1) begin
            if (r_rd_p1 != 3'd0)
                r_rf[r_rd_p1] <= bus.alu_result;
            if (r_retired != {RETIRE_W{1'b1}})
                r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    assign bus.instr_ready     = !r_halted;
    assign bus.exe_valid       = r_vld_p1;
    assign bus.exe_operand1    = r_op1_p1;
    assign bus.exe_operand2    = r_op2_p1;
    assign bus.exe_alu_control = r_ctrl_p1;

    assign dbg_data = (dbg_addr == 3'd0) ? '0 : r_rf[dbg_addr];
    assign retired  = r_retired;
    assign halted   = r_halted;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: an in-order architectural model predicts every
// issued operand set, a negedge monitor checks the execute bus, and idle-time debug reads check state.
module tb_alu_issue_unit;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int RET_MAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    dbg_addr = 3'd0;
    logic [DW-1:0] dbg_data;
    logic [RW-1:0] retired;
    logic          halted;

    alu_issue_if #(.DATA_W(DW)) bus ();

    alu_issue_unit #(.DATA_W(DW), .RETIRE_W(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .retired  (retired),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a << b[4:0];
            3'd5:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Combinational ALU environment driven by the issue unit's execute bus.
    always_comb begin
        bus.alu_result = ref_alu(bus.exe_alu_control, bus.exe_operand1, bus.exe_operand2);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mrf [8];
    int          mret;
    bit          mhalt;
    bit          exp_vld;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int isel, input int rd,
                                        input int rs1, input int rs2, input int imm);
        logic [31:0] w;
        w = {op[2:0], isel[0], rd[2:0], rs1[2:0], rs2[2:0], imm[18:0]};
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mrf[k] = 32'd0;
        mret    = 0;
        mhalt   = 1'b0;
        exp_vld = 1'b0;
        sb.delete();
    endtask

    // Architectural model: each accepted instruction completes immediately in program order.
    task automatic model_step(input bit acc, input logic [31:0] ins);
        logic [2:0]  op;
        logic [31:0] a, b, r, sx;
        exp_t        e;
        exp_vld = 1'b0;
        if (acc) begin
            op = ins[31:29];
            if (op <= 3'd5) begin
                sx = {{13{ins[18]}}, ins[18:0]};
                a  = (ins[24:22] == 3'd0) ? 32'd0 : mrf[ins[24:22]];
                b  = ins[28] ? sx : ((ins[21:19] == 3'd0) ? 32'd0 : mrf[ins[21:19]]);
                e.a = a; e.b = b; e.c = op;
                sb.push_back(e);
                r = ref_alu(op, a, b);
                if (ins[27:25] != 3'd0) mrf[ins[27:25]] = r;
                if (mret < RET_MAX) mret++;
                exp_vld = 1'b1;
            end else if (op == 3'd7) begin
                mhalt = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins);
        bit acc;
        @(negedge clk);
        bus.instr_valid = v;
        bus.instr       = ins;
        acc = v && !mhalt;
        @(posedge clk);
        model_step(acc, ins);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 32'd0);
    endtask

    task automatic check_dbg(input string nm, input int addr, input logic [31:0] exp);
        @(negedge clk);
        dbg_addr = addr[2:0];
        #1;
        chk(nm, dbg_data, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        dbg_addr = 3'd3;
        #1;
        chk("rst_exe_valid", {31'd0, bus.exe_valid}, 32'd0);
        chk("rst_operand1", bus.exe_operand1, 32'd0);
        chk("rst_operand2", bus.exe_operand2, 32'd0);
        chk("rst_alu_control", {29'd0, bus.exe_alu_control}, 32'd0);
        chk("rst_retired", {28'd0, retired}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_dbg_r3", dbg_data, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        chk("rst_release_ready", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    // Monitor: compares the execute bus against the scoreboard on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("exe_valid", {31'd0, bus.exe_valid}, {31'd0, exp_vld});
            chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, !mhalt});
            chk("halted", {31'd0, halted}, {31'd0, mhalt});
            if (bus.exe_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_issue", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("exe_operand1", bus.exe_operand1, e.a);
                    chk("exe_operand2", bus.exe_operand2, e.b);
                    chk("exe_alu_control", {29'd0, bus.exe_alu_control}, {29'd0, e.c});
                end
            end
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        bus.instr_valid = 1'b0;
        bus.instr = 32'd0;
        model_reset();
        do_reset();

        // Dependent pair through the bypass, then a negative immediate.
        drive(1'b1, enc(0, 1, 1, 0, 0, 5));
        drive(1'b1, enc(0, 0, 2, 1, 1, 0));
        drive(1'b1, enc(1, 1, 3, 0, 0, 19'h7FFFF));
        idle(2);
        check_dbg("t2_r1", 1, 32'd5);
        check_dbg("t2_r2", 2, 32'd10);
        check_dbg("t3_r3", 3, 32'h00000001);
        chk("t2_retired", {28'd0, retired}, 32'd3);

        do_reset();
        drive(1'b1, enc(0, 1, 0, 0, 0, 7));
        idle(2);
        check_dbg("t4_r0", 0, 32'd0);
        chk("t4_retired", {28'd0, retired}, 32'd1);
        drive(1'b1, enc(0, 1, 1, 0, 0, 5));
        drive(1'b1, enc(4, 1, 4, 1, 0, 4));
        idle(2);
        check_dbg("t4_r4", 4, 32'h50);

        // Gaps and a NOP between dependents.
        drive(1'b1, enc(0, 0, 5, 4, 1, 0));
        idle(1);
        drive(1'b1, enc(6, 0, 6, 5, 5, 0));
        drive(1'b1, enc(0, 0, 6, 5, 5, 0));
        idle(1);
        drive(1'b1, enc(1, 0, 7, 6, 5, 0));
        idle(2);
        check_dbg("t6_r5", 5, 32'h55);
        check_dbg("t6_r6", 6, 32'hAA);
        check_dbg("t6_r7", 7, 32'h55);

        // Randomized traffic with a reset landing mid-stream.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
            end else begin
                bit v;
                int op, imm;
                v   = ($urandom_range(0, 3) != 0);
                op  = $urandom_range(0, 6);
                imm = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : $urandom();
                drive(v, enc(op, $urandom_range(0, 1), $urandom_range(0, 7),
                             $urandom_range(0, 7), $urandom_range(0, 7), imm));
            end
        end
        idle(2);
        for (int k = 0; k < 8; k++) check_dbg("rand_rf", k, mrf[k]);
        chk("rand_retired", {28'd0, retired}, mret);

        // Halt blocks the following instruction for good.
        do_reset();
        drive(1'b1, enc(0, 1, 1, 0, 0, 1));
        drive(1'b1, enc(7, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) drive(1'b1, enc(0, 1, 1, 0, 0, 9));
        idle(2);
        chk("t5_halted", {31'd0, halted}, 32'd1);
        check_dbg("t5_r1", 1, 32'd1);
        chk("t5_retired", {28'd0, retired}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
